// File: rtl/block_sequencer.sv
// Frame sequencer: splits an NxN image into MxM blocks, streams header/primary/watermark pixels to a block processor, writes its results back.
// Reads lead the pixel stream by one cycle; COLLECT waits for proc_new_pixel (optional BLK_SEQ_WATCHDOG_EN bounds that wait).
`timescale 1ns/1ps
module block_sequencer #(
    parameter int Data_Depth     = 8,
    parameter int Addr_Width     = 19,
    parameter int Max_Block_Size = 5184
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [9:0]            cfg_n_i,
    input  logic [Data_Depth-1:0] cfg_m_i,
    input  logic                  hdr_wr_i,
    input  logic [3:0]            hdr_idx_i,
    input  logic [Data_Depth-1:0] hdr_data_i,
    output logic                  img_rd_o,
    output logic                  img_sel_o,
    output logic [Addr_Width-1:0] img_addr_o,
    input  logic [Data_Depth-1:0] img_data_i,
    output logic                  proc_rst_o,
    output logic                  proc_en_o,
    output logic [Data_Depth-1:0] proc_pixel_o,
    input  logic                  proc_new_pixel_i,
    input  logic [Data_Depth-1:0] proc_result_i,
    output logic                  out_we_o,
    output logic [Addr_Width-1:0] out_addr_o,
    output logic [Data_Depth-1:0] out_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int CW = 2 * Data_Depth;

    typedef enum logic [2:0] {IDLE, PRST, PRE, HDR, PRIM, WMK, COLLECT, NEXT} state_t;

    state_t                state_q, state_d;
    logic [9:0]            n_q, n_d, m_q, m_d;
    logic [9:0]            brow_q, brow_d, bcol_q, bcol_d;
    logic [9:0]            rd_r_q, rd_r_d, rd_c_q, rd_c_d, wr_r_q, wr_r_d, wr_c_q, wr_c_d;
    logic                  rd_sel_q, rd_sel_d, first_q, first_d;
    logic [3:0]            hcnt_q, hcnt_d;
    logic [CW-1:0]         cnt_q, cnt_d, wcnt_q, wcnt_d;
    logic                  out_we_q, out_we_d, done_q, done_d, err_q, err_d;
    logic [Addr_Width-1:0] out_addr_q, out_addr_d;
    logic [Data_Depth-1:0] out_data_q, out_data_d;
    logic [Data_Depth-1:0] hdr_q [0:8];
`ifdef BLK_SEQ_WATCHDOG_EN
    logic [9:0]            wd_q, wd_d;
`endif

    logic                  img_rd, wd_trip, cfg_ok, last_blk;
    logic [31:0]           cn, cm;
    logic [CW-1:0]         mm, mm_last;
    logic [9:0]            m_last;
    logic [Addr_Width-1:0] rd_addr, wr_addr;

    assign cn      = 32'(cfg_n_i);
    assign cm      = 32'(cfg_m_i);
    assign cfg_ok  = (cm != 32'd0) && (cm <= cn) && ((cn % cm) == 32'd0) &&
                     ((cm * cm) <= 32'(Max_Block_Size));
    assign mm      = CW'(m_q) * CW'(m_q);
    assign mm_last = mm - CW'(1);
    assign m_last  = m_q - 10'd1;
    assign last_blk = (brow_q + m_q == n_q) && (bcol_q + m_q == n_q);
    // Block origin is kept in pixels (brow/bcol), so no multiply by M is needed here.
    assign rd_addr = Addr_Width'(brow_q + rd_r_q) * Addr_Width'(n_q) + Addr_Width'(bcol_q + rd_c_q);
    assign wr_addr = Addr_Width'(brow_q + wr_r_q) * Addr_Width'(n_q) + Addr_Width'(bcol_q + wr_c_q);

    always_comb begin
        state_d = state_q;   n_d = n_q;           m_d = m_q;         first_d = first_q;
        brow_d = brow_q;     bcol_d = bcol_q;     hcnt_d = hcnt_q;   cnt_d = cnt_q;
        wcnt_d = wcnt_q;     rd_r_d = rd_r_q;     rd_c_d = rd_c_q;   rd_sel_d = rd_sel_q;
        wr_r_d = wr_r_q;     wr_c_d = wr_c_q;     out_we_d = 1'b0;   out_addr_d = out_addr_q;
        out_data_d = out_data_q; done_d = 1'b0;   err_d = err_q;     wd_trip = 1'b0;
        img_rd = 1'b0;       proc_en_o = 1'b0;    proc_pixel_o = '0;
`ifdef BLK_SEQ_WATCHDOG_EN
        wd_d = wd_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                if (cfg_ok) begin
                    n_d = cfg_n_i;  m_d = 10'(cfg_m_i);  err_d = 1'b0;  first_d = 1'b1;
                    brow_d = '0;  bcol_d = '0;  rd_r_d = '0;  rd_c_d = '0;  rd_sel_d = 1'b0;
                    wr_r_d = '0;  wr_c_d = '0;  cnt_d = '0;   wcnt_d = '0;  hcnt_d = '0;
                    state_d = PRST;
                end else begin
                    err_d = 1'b1;
                end
            end
            PRST: state_d = PRE;
            PRE: begin
                proc_en_o = 1'b1;
                cnt_d     = '0;
                hcnt_d    = '0;
                if (first_q) begin
                    state_d = HDR;
                end else begin
                    img_rd  = 1'b1;
                    state_d = PRIM;
                end
            end
            HDR: begin
                proc_en_o    = 1'b1;
                proc_pixel_o = hdr_q[hcnt_q];
                hcnt_d       = hcnt_q + 4'd1;
                if (hcnt_q == 4'd8) begin
                    img_rd  = 1'b1;
                    state_d = PRIM;
                end
            end
            PRIM: begin
                proc_en_o    = 1'b1;
                proc_pixel_o = img_data_i;
                img_rd       = 1'b1;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == mm_last) begin
                    cnt_d   = '0;
                    state_d = WMK;
                end
            end
            WMK: begin
                proc_en_o    = 1'b1;
                proc_pixel_o = img_data_i;
                if (cnt_q == mm_last) begin
                    cnt_d   = '0;
                    state_d = COLLECT;
`ifdef BLK_SEQ_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    img_rd = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            COLLECT: begin
                proc_en_o = 1'b1;
                if (proc_new_pixel_i) begin
                    out_we_d   = 1'b1;
                    out_addr_d = wr_addr;
                    out_data_d = proc_result_i;
                    wcnt_d     = wcnt_q + CW'(1);
                    if (wr_c_q == m_last) begin
                        wr_c_d = '0;
                        wr_r_d = (wr_r_q == m_last) ? 10'd0 : wr_r_q + 10'd1;
                    end else begin
                        wr_c_d = wr_c_q + 10'd1;
                    end
                    if (wcnt_q == mm_last) begin
                        wcnt_d  = '0;
                        state_d = NEXT;
                    end
                end
`ifdef BLK_SEQ_WATCHDOG_EN
                if (proc_new_pixel_i) begin
                    wd_d = '0;
                end else if (wd_q == 10'd1023) begin
                    wd_trip = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 10'd1;
                end
`endif
            end
            NEXT: begin
                first_d = 1'b0;
                if (last_blk) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (bcol_q + m_q == n_q) begin
                        bcol_d = '0;
                        brow_d = brow_q + m_q;
                    end else begin
                        bcol_d = bcol_q + m_q;
                    end
                    state_d = PRE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Read cursor walks primary block then watermark block, returning to origin.
        if (img_rd) begin
            if (rd_c_q == m_last) begin
                rd_c_d = '0;
                if (rd_r_q == m_last) begin
                    rd_r_d   = '0;
                    rd_sel_d = ~rd_sel_q;
                end else begin
                    rd_r_d = rd_r_q + 10'd1;
                end
            end else begin
                rd_c_d = rd_c_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;  n_q <= '0;  m_q <= '0;  first_q <= 1'b0;
            brow_q <= '0;  bcol_q <= '0;  hcnt_q <= '0;  cnt_q <= '0;  wcnt_q <= '0;
            rd_r_q <= '0;  rd_c_q <= '0;  rd_sel_q <= 1'b0;  wr_r_q <= '0;  wr_c_q <= '0;
            out_we_q <= 1'b0;  out_addr_q <= '0;  out_data_q <= '0;
            done_q <= 1'b0;  err_q <= 1'b0;
`ifdef BLK_SEQ_WATCHDOG_EN
            wd_q <= '0;
`endif
        end else begin
            state_q <= state_d;  n_q <= n_d;  m_q <= m_d;  first_q <= first_d;
            brow_q <= brow_d;  bcol_q <= bcol_d;  hcnt_q <= hcnt_d;  cnt_q <= cnt_d;  wcnt_q <= wcnt_d;
            rd_r_q <= rd_r_d;  rd_c_q <= rd_c_d;  rd_sel_q <= rd_sel_d;  wr_r_q <= wr_r_d;  wr_c_q <= wr_c_d;
            out_we_q <= out_we_d;  out_addr_q <= out_addr_d;  out_data_q <= out_data_d;
            done_q <= done_d;  err_q <= err_d;
`ifdef BLK_SEQ_WATCHDOG_EN
            wd_q <= wd_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 9; i++) hdr_q[i] <= '0;
        end else if (hdr_wr_i && state_q == IDLE && hdr_idx_i <= 4'd8) begin
            hdr_q[hdr_idx_i] <= hdr_data_i;
        end
    end

    assign img_rd_o   = img_rd;
    assign img_sel_o  = img_rd & rd_sel_q;
    assign img_addr_o = img_rd ? rd_addr : '0;
    assign proc_rst_o = rst_i | (state_q == PRST) | wd_trip;
    assign out_we_o   = out_we_q;
    assign out_addr_o = out_addr_q;
    assign out_data_o = out_data_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_block_sequencer.sv
// Scoreboard bench for block_sequencer: expected reads/writes/header beats are queued at stimulus time and checked by monitors.
`timescale 1ns/1ps
module tb_block_sequencer;
    localparam int DD = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst, start, hdr_wr, img_rd, img_sel, proc_rst, proc_en;
    logic          proc_new_pixel = 1'b0, out_we, busy, done, err;
    logic [9:0]    cfg_n;
    logic [DD-1:0] cfg_m, hdr_data, img_data = '0, proc_pixel, proc_result = '0, out_data;
    logic [3:0]    hdr_idx;
    logic [AW-1:0] img_addr, out_addr;

    always #5 clk = ~clk;

    block_sequencer #(.Data_Depth(DD), .Addr_Width(AW), .Max_Block_Size(5184)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_n_i(cfg_n), .cfg_m_i(cfg_m),
        .hdr_wr_i(hdr_wr), .hdr_idx_i(hdr_idx), .hdr_data_i(hdr_data),
        .img_rd_o(img_rd), .img_sel_o(img_sel), .img_addr_o(img_addr), .img_data_i(img_data),
        .proc_rst_o(proc_rst), .proc_en_o(proc_en), .proc_pixel_o(proc_pixel),
        .proc_new_pixel_i(proc_new_pixel), .proc_result_i(proc_result),
        .out_we_o(out_we), .out_addr_o(out_addr), .out_data_o(out_data),
        .busy_o(busy), .done_o(done), .err_o(err));

    int vec_cnt = 0, err_cnt = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, hdr_beats = 0;
    int tb_mm = 4, res_limit = 1000000;
    logic [AW:0]      exp_rd [$];
    logic [AW+DD-1:0] exp_wr [$];
    logic [DD-1:0]    exp_hdr [$];
    logic [AW-1:0]    prim_log [$];
    logic [AW-1:0]    wr_log [$];
    logic [DD-1:0]    cur_hdr [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_extra(input string name, input logic [31:0] act);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: got %0d, expected nothing", name, act);
    endtask

    function automatic logic [DD-1:0] prim_px(input logic [AW-1:0] a);
        return DD'((32'(a) * 37 + 11) & 255);
    endfunction
    function automatic logic [DD-1:0] wm_px(input logic [AW-1:0] a);
        return DD'((32'(a) * 5 + 200) & 255);
    endfunction

    // Image memory: one-cycle read latency.
    always @(posedge clk) if (img_rd) img_data <= img_sel ? wm_px(img_addr) : prim_px(img_addr);

    // Read/write/done monitor.
    always @(negedge clk) begin
        if (img_rd) begin
            rd_cnt++;
            if (!img_sel) prim_log.push_back(img_addr);
            if (exp_rd.size() == 0) chk_extra("rd_extra", {img_sel, img_addr});
            else chk("rd_addr_sel", {img_sel, img_addr}, exp_rd.pop_front());
        end
        if (out_we) begin
            wr_cnt++;
            wr_log.push_back(out_addr);
            if (exp_wr.size() == 0) chk_extra("wr_extra", out_addr);
            else chk("wr_addr_data", {out_addr, out_data}, exp_wr.pop_front());
        end
        if (done) done_cnt++;
    end

    // Block processor model: idle step, optional header, M*M primary, M*M watermark, then echo primary.
    int beat = 0, emitted = 0, total_res = 0, skip = 0;
    bit first_blk = 1'b1, emitting = 1'b0;
    logic [DD-1:0] pq [$];
    always @(posedge clk) begin
        int h;
        proc_new_pixel <= 1'b0;
        if (proc_rst) begin
            beat = 0; emitted = 0; total_res = 0; skip = 0; first_blk = 1'b1; emitting = 1'b0;
            pq.delete();
        end else if (skip != 0) begin
            skip = 0;
        end else if (emitting) begin
            if (total_res < res_limit && pq.size() > 0) begin
                proc_new_pixel <= 1'b1;
                proc_result    <= pq.pop_front();
                emitted++;
                total_res++;
                if (emitted == tb_mm) begin
                    emitting = 1'b0; emitted = 0; beat = 0; first_blk = 1'b0; skip = 1;
                end
            end
        end else if (proc_en) begin
            h = first_blk ? 9 : 0;
            if (beat == 0) chk("pre_idle_px", proc_pixel, 0);
            if (first_blk && beat >= 1 && beat <= 9) begin
                hdr_beats++;
                if (exp_hdr.size() == 0) chk_extra("hdr_extra", proc_pixel);
                else chk("hdr_beat", proc_pixel, exp_hdr.pop_front());
            end
            if (beat >= 1 + h && beat < 1 + h + tb_mm) pq.push_back(proc_pixel);
            beat++;
            if (beat == 1 + h + 2 * tb_mm) emitting = 1'b1;
        end
    end

    task automatic push_frame(input int n, input int m);
        int a;
        for (int br = 0; br < n / m; br++)
            for (int bc = 0; bc < n / m; bc++) begin
                for (int s = 0; s < 2; s++)
                    for (int r = 0; r < m; r++)
                        for (int c = 0; c < m; c++) begin
                            a = (br * m + r) * n + bc * m + c;
                            exp_rd.push_back({s[0], AW'(a)});
                        end
                for (int r = 0; r < m; r++)
                    for (int c = 0; c < m; c++) begin
                        a = (br * m + r) * n + bc * m + c;
                        exp_wr.push_back({AW'(a), prim_px(AW'(a))});
                    end
            end
        for (int i = 0; i < 9; i++) exp_hdr.push_back(cur_hdr[i]);
        tb_mm = m * m;
    endtask

    task automatic pulse_start(input int n, input int m);
        cfg_n = 10'(n);
        cfg_m = DD'(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clk);
        chk(name, done_cnt - d0, 1);
    endtask

    task automatic flush();
        exp_rd.delete(); exp_wr.delete(); exp_hdr.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, h0, d0, hv[9], wexp[16], rexp[9];
        bit seen;
        hv   = '{255, 1, 1, 2, 50, 10, 90, 10, 90};
        wexp = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        rexp = '{18, 19, 20, 24, 25, 26, 30, 31, 32};
        rst = 1'b1; start = 1'b0; cfg_n = '0; cfg_m = '0; hdr_wr = 1'b0; hdr_idx = '0; hdr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);        chk("rst_done", done, 0);      chk("rst_err", err, 0);
        chk("rst_img_rd", img_rd, 0);    chk("rst_proc_en", proc_en, 0); chk("rst_out_we", out_we, 0);
        chk("rst_proc_rst", proc_rst, 1); chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0); chk("rst_proc_pixel", proc_pixel, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_proc_rst", proc_rst, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            hdr_wr = 1'b1; hdr_idx = 4'(i); hdr_data = DD'(hv[i]); cur_hdr[i] = DD'(hv[i]);
            @(posedge clk); #1;
        end
        hdr_wr = 1'b0;

        // N=4, M=2 frame, echoed image must equal primary.
        w0 = wr_cnt; h0 = hdr_beats; d0 = done_cnt; wr_log.delete();
        push_frame(4, 2);
        pulse_start(4, 2);
        @(negedge clk);
        chk("busy_running", busy, 1);
        wait_done(600, "n4_done");
        repeat (4) @(negedge clk);
        chk("n4_done_once", done_cnt - d0, 1);
        chk("n4_writes", wr_cnt - w0, 16);
        chk("n4_hdr_beats", hdr_beats - h0, 9);
        chk("n4_busy_end", busy, 0);
        chk("n4_rd_left", exp_rd.size(), 0);
        for (int i = 0; i < 16; i++) if (i < wr_log.size()) chk("n4_wr_order", wr_log[i], wexp[i]);

        // Invalid configuration: N not a multiple of M.
        r0 = rd_cnt;
        pulse_start(5, 2);
        @(negedge clk);
        chk("bad_cfg_err", err, 1);
        chk("bad_cfg_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("bad_cfg_no_rd", rd_cnt - r0, 0);
        chk("bad_cfg_err_sticky", err, 1);

        // Start pulse during COLLECT must be ignored.
        w0 = wr_cnt; d0 = done_cnt; h0 = hdr_beats; seen = 1'b0;
        push_frame(4, 2);
        pulse_start(4, 2);
        @(negedge clk);
        chk("err_cleared", err, 0);
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (proc_new_pixel) seen = 1'b1;
        end
        chk("collect_seen", seen, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(600, "restart_done");
        repeat (4) @(negedge clk);
        chk("restart_writes", wr_cnt - w0, 16);
        chk("restart_done_once", done_cnt - d0, 1);
        chk("restart_hdr_beats", hdr_beats - h0, 9);

        // N=6, M=3: block (1,0) primary reads.
        w0 = wr_cnt; prim_log.delete();
        push_frame(6, 3);
        pulse_start(6, 3);
        wait_done(1500, "n6_done");
        repeat (2) @(negedge clk);
        chk("n6_writes", wr_cnt - w0, 36);
        for (int i = 0; i < 9; i++) if (18 + i < prim_log.size()) chk("n6_blk10_rd", prim_log[18 + i], rexp[i]);

        // Reset during WMK of the second block.
        r0 = rd_cnt; seen = 1'b0;
        push_frame(4, 2);
        pulse_start(4, 2);
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk);
            if (rd_cnt - r0 >= 14) seen = 1'b1;
        end
        chk("wmk_reached", seen, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_proc_rst_now", proc_rst, 1);
        @(negedge clk);
        chk("midrst_busy", busy, 0);      chk("midrst_img_rd", img_rd, 0);
        chk("midrst_proc_en", proc_en, 0); chk("midrst_out_we", out_we, 0);
        chk("midrst_done", done, 0);       chk("midrst_proc_rst", proc_rst, 1);
        @(posedge clk); #1 rst = 1'b0;
        flush();
        for (int i = 0; i < 9; i++) cur_hdr[i] = '0;
        w0 = wr_cnt; h0 = hdr_beats;
        push_frame(4, 2);
        pulse_start(4, 2);
        wait_done(600, "postrst_done");
        repeat (2) @(negedge clk);
        chk("postrst_hdr_beats", hdr_beats - h0, 9);
        chk("postrst_writes", wr_cnt - w0, 16);

`ifdef BLK_SEQ_WATCHDOG_EN
        // Processor falls silent after two results.
        w0 = wr_cnt; d0 = done_cnt; seen = 1'b0; res_limit = 2;
        push_frame(4, 2);
        pulse_start(4, 2);
        for (int k = 0; k < 1400 && !seen; k++) begin
            @(negedge clk);
            if (err) seen = 1'b1;
        end
        chk("wd_err", err, 1);
        @(negedge clk);
        chk("wd_busy", busy, 0);
        chk("wd_no_done", done_cnt - d0, 0);
        chk("wd_writes", wr_cnt - w0, 2);
        flush();
        res_limit = 1000000;
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
